// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: the ID and ID/EX
// fields it inspects, the enables and flushes it drives, and the debug
// counters it exposes.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_ifid_rs;
  logic [4:0]       i_ifid_rt;
  logic             i_ifid_uses_rt;
  logic [2:0]       i_idex_mem_control;
  logic [4:0]       i_idex_tar_reg;
  logic             i_branch_taken;
  logic             i_cnt_clr;
  logic             o_pc_write;
  logic             o_ifid_write;
  logic             o_ifid_flush;
  logic             o_idex_bubble;
  logic             o_exmem_flush;
  logic             o_stalled;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  // pipeline side: supplies the fields, consumes the controls
  modport master (
    output i_ifid_rs, i_ifid_rt, i_ifid_uses_rt, i_idex_mem_control,
           i_idex_tar_reg, i_branch_taken, i_cnt_clr,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
           o_exmem_flush, o_stalled, o_stall_cnt, o_flush_cnt
  );

  // controller side
  modport slave (
    input  i_ifid_rs, i_ifid_rt, i_ifid_uses_rt, i_idex_mem_control,
           i_idex_tar_reg, i_branch_taken, i_cnt_clr,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
           o_exmem_flush, o_stalled, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / taken-branch hazard controller.
//
//   state | meaning
//   RUN   | normal issue; detects load-use hazards and branch flushes
//   STALL | extra load-latency stall cycles; detection ignored
//
// Control outputs are Mealy: a stall or flush acts in the same cycle the
// condition is presented. A taken branch always wins over a stall.
module hazard_stall_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  hazard_stall_ctrl_if.slave   bus
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [2:0] REMAIN_INIT = 3'(LOAD_LAT - 1);

  state_t           state, state_nxt;
  logic [2:0]       remain, remain_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             hazard;
  logic             stall_inc, flush_inc;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;

  // load in ID/EX whose destination is read by the instruction in ID
  always_comb begin
    hazard = bus.i_idex_mem_control[1] && (bus.i_idex_tar_reg != 5'd0) &&
             ((bus.i_idex_tar_reg == bus.i_ifid_rs) ||
              (bus.i_ifid_uses_rt && (bus.i_idex_tar_reg == bus.i_ifid_rt)));
  end

  // next state, remain count and Mealy control outputs
  always_comb begin
    state_nxt   = state;
    remain_nxt  = remain;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      RUN: begin
        if (bus.i_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt  = STALL;
            remain_nxt = REMAIN_INIT;
          end
        end
      end
      STALL: begin
        if (bus.i_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
          state_nxt   = RUN;
          remain_nxt  = 3'd0;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          remain_nxt  = remain - 3'd1;
          if (remain == 3'd1) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt  = RUN;
        remain_nxt = 3'd0;
      end
    endcase
    // outputs are pinned to free-running values while reset is held
    if (!i_rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  // sequencer state and remaining stall cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= RUN;
      remain <= 3'd0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // saturating event counters; clear wins over increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.o_pc_write    = pc_write;
  assign bus.o_ifid_write  = ifid_write;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_bubble = idex_bubble;
  assign bus.o_exmem_flush = exmem_flush;
  assign bus.o_stalled     = (state == STALL);
  assign bus.o_stall_cnt   = stall_cnt;
  assign bus.o_flush_cnt   = flush_cnt;

endmodule
